// File: rtl/spi_master_pkg.sv
// Shared definitions for the parametrised SPI master: mode codes, FSM encoding
// and the slave-select index width helper.
package spi_master_pkg;

  localparam logic [1:0] SPI_MODE0 = 2'b00;
  localparam logic [1:0] SPI_MODE1 = 2'b01;
  localparam logic [1:0] SPI_MODE2 = 2'b10;
  localparam logic [1:0] SPI_MODE3 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LEAD  = 3'd2,
    ST_TRAIL = 3'd3,
    ST_DONE  = 3'd4
  } spi_state_t;

  function automatic int ss_w(input int num_ss);
    if (num_ss <= 1) return 1;
    return $clog2(num_ss);
  endfunction

endpackage

// File: rtl/spi_sck_tick.sv
// SCK half-period timer: down-counter reloaded on start or terminal count,
// emitting a one-clock tick every div+1 clocks while enabled.
module spi_sck_tick #(
  parameter int DIV_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
      r_div <= '0;
    end else if (i_start) begin
      r_cnt <= i_div;
      r_div <= i_div;
    end else if (i_en) begin
      if (r_cnt == '0) r_cnt <= r_div;
      else             r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == '0);

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master with per-transfer mode, held chip-select and a
// one-entry RX holding register. Optional feature macro: SPI_LOOPBACK_EN.
//
// state    | meaning
// IDLE     | SCK at CPOL, waiting for an accepted start
// SETUP    | SS asserted, first bit presented (CPHA=0)
// LEAD     | SCK at ~CPOL; sample (CPHA=0) or shift out (CPHA=1)
// TRAIL    | SCK at CPOL; shift out (CPHA=0) or sample (CPHA=1)
// DONE     | SS deasserted on exit
module spi_master_param
  import spi_master_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 1,
  parameter int DIV_W  = 8
) (
  input  logic                      control_clk_i,
  input  logic                      control_rst_i,
  input  logic                      control_we_i,
  input  logic [DATA_W-1:0]         control_dataw_i,
  input  logic [DIV_W-1:0]          control_div_i,
  input  logic [1:0]                control_mode_i,
  input  logic [ss_w(NUM_SS)-1:0]   control_ss_sel_i,
  input  logic                      control_hold_ss_i,
  input  logic                      control_re_i,
`ifdef SPI_LOOPBACK_EN
  input  logic                      loopback_i,
`endif
  output logic [DATA_W-1:0]         mem_data_o,
  output logic                      busy_o,
  output logic                      rx_valid_o,
  output logic                      rx_ovf_o,
  output logic                      SCK,
  output logic [NUM_SS-1:0]         SS,
  output logic                      MOSI,
  input  logic                      MISO
);

  localparam int SSW   = ss_w(NUM_SS);
  localparam int CNT_W = $clog2(DATA_W);

  spi_state_t        r_state;
  spi_state_t        w_next;
  logic [1:0]        r_mode;
  logic              r_hold;
  logic              r_mosi;
  logic [DATA_W-1:0] r_tx;
  logic [DATA_W-1:0] r_rx;
  logic [DATA_W-1:0] r_mem;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [NUM_SS-1:0] r_ss;
  logic              r_valid;
  logic              r_ovf;

  logic              w_start;
  logic              w_tick;
  logic              w_cpol;
  logic              w_cpha;
  logic              w_last_bit;
  logic              w_sample;
  logic              w_shift_out;
  logic              w_sample_bit;
  logic              w_complete;
  logic              w_sck;
  logic              w_busy;
  logic [DATA_W-1:0] w_rx_shift;
  logic [DATA_W-1:0] w_rx_cur;
  logic [NUM_SS-1:0] w_ss_start;

  assign w_start    = control_we_i && (r_state == ST_IDLE);
  assign w_cpol     = (r_mode == SPI_MODE2) || (r_mode == SPI_MODE3);
  assign w_cpha     = (r_mode == SPI_MODE1) || (r_mode == SPI_MODE3);
  assign w_last_bit = (r_bit_cnt == '0);

  spi_sck_tick #(.DIV_W(DIV_W)) u_tick (
    .i_clk   (control_clk_i),
    .i_rst_n (control_rst_i),
    .i_start (w_start),
    .i_en    (r_state != ST_IDLE),
    .i_div   (control_div_i),
    .o_tick  (w_tick)
  );

  // FSM state register
  always_ff @(posedge control_clk_i or negedge control_rst_i) begin
    if (!control_rst_i) r_state <= ST_IDLE;
    else                r_state <= w_next;
  end

  // FSM next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_next = ST_SETUP;
      ST_SETUP: if (w_tick) w_next = ST_LEAD;
      ST_LEAD:  if (w_tick) w_next = ST_TRAIL;
      ST_TRAIL: begin
        if (w_tick) begin
          if (!w_last_bit) w_next = ST_LEAD;
          else if (r_hold) w_next = ST_IDLE;
          else             w_next = ST_DONE;
        end
      end
      ST_DONE:  if (w_tick) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_sck  = w_cpol;
    w_busy = 1'b1;
    case (r_state)
      ST_IDLE: w_busy = 1'b0;
      ST_LEAD: w_sck  = ~w_cpol;
      default: ;
    endcase
  end

  // The sampled bit of the final TRAIL (CPHA=1) lands on the same edge as
  // completion when SS is held, so completion takes the bypassed value.
  assign w_sample    = w_tick && (((r_state == ST_LEAD) && !w_cpha) ||
                                  ((r_state == ST_TRAIL) && w_cpha));
  assign w_shift_out = w_tick && (w_cpha ? ((w_next == ST_LEAD) && (r_state != ST_LEAD))
                                         : (r_state == ST_LEAD));
  assign w_rx_shift  = {r_rx[DATA_W-2:0], w_sample_bit};
  assign w_rx_cur    = w_sample ? w_rx_shift : r_rx;
  assign w_complete  = (r_state != ST_IDLE) && (w_next == ST_IDLE);

`ifdef SPI_LOOPBACK_EN
  logic r_loop;

  always_ff @(posedge control_clk_i or negedge control_rst_i) begin
    if (!control_rst_i)  r_loop <= 1'b0;
    else if (w_start)    r_loop <= loopback_i;
  end

  assign w_sample_bit = r_loop ? r_mosi : MISO;
`else
  assign w_sample_bit = MISO;
`endif

  always_comb begin
    w_ss_start = '1;
    for (int i = 0; i < NUM_SS; i++) begin
      if (control_ss_sel_i == SSW'(i)) w_ss_start[i] = 1'b0;
    end
`ifdef SPI_LOOPBACK_EN
    if (loopback_i) w_ss_start = '1;
`endif
  end

  always_ff @(posedge control_clk_i or negedge control_rst_i) begin
    if (!control_rst_i) begin
      r_mode    <= SPI_MODE0;
      r_hold    <= 1'b0;
      r_mosi    <= 1'b0;
      r_tx      <= '0;
      r_rx      <= '0;
      r_bit_cnt <= '0;
      r_ss      <= '1;
    end else begin
      if (w_start) begin
        r_mode    <= control_mode_i;
        r_hold    <= control_hold_ss_i;
        r_bit_cnt <= CNT_W'(DATA_W - 1);
        r_ss      <= w_ss_start;
        if (control_mode_i[0]) begin
          r_tx <= control_dataw_i;
        end else begin
          r_tx   <= {control_dataw_i[DATA_W-2:0], 1'b0};
          r_mosi <= control_dataw_i[DATA_W-1];
        end
      end
      if (w_shift_out) begin
        r_mosi <= r_tx[DATA_W-1];
        r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
      end
      if (w_sample) r_rx <= w_rx_shift;
      if (w_tick && (r_state == ST_TRAIL) && !w_last_bit) r_bit_cnt <= r_bit_cnt - 1'b1;
      if (w_tick && (r_state == ST_DONE)) r_ss <= '1;
    end
  end

  // RX holding register; a read in the completion cycle wins over overflow
  always_ff @(posedge control_clk_i or negedge control_rst_i) begin
    if (!control_rst_i) begin
      r_mem   <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_complete) begin
      r_mem   <= w_rx_cur;
      r_valid <= 1'b1;
      if (control_re_i)  r_ovf <= 1'b0;
      else if (r_valid)  r_ovf <= 1'b1;
    end else if (control_re_i) begin
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end
  end

  assign mem_data_o = r_mem;
  assign busy_o     = w_busy;
  assign rx_valid_o = r_valid;
  assign rx_ovf_o   = r_ovf;
  assign SCK        = w_sck;
  assign SS         = r_ss;
  assign MOSI       = r_mosi;

endmodule

// File: doc/spi_master_param.md
Name: spi_master_param

Overview:
- Parametrised SPI master, the next generation of the microSD SPI engine.
- Configurable word width, slave-select count and SCK divider; all four CPOL/CPHA modes selectable per transfer.
- Optional held chip-select for multi-word SD commands; one-entry RX holding register with overflow flag.
- Sits between the bootstrap control logic (start/read handshake) and the SD card / SPI flash pins.

Parameters:
- DATA_W, 8, bits per transfer word (4..32), MSB first.
- NUM_SS, 1, number of active-low slave selects (1..8).
- DIV_W, 8, width of the SCK half-period divider input.

Ports:
- control_clk_i  in  1  system clock.
- control_rst_i  in  1  asynchronous active-low reset.
- control_we_i  in  1  start pulse; accepted only when busy_o=0.
- control_dataw_i  in  DATA_W  TX word, latched on accepted start.
- control_div_i  in  DIV_W  SCK half period = control_div_i+1 clocks; latched at start.
- control_mode_i  in  2  {CPOL,CPHA}; latched at start.
- control_ss_sel_i  in  max(1,clog2(NUM_SS))  slave index; latched at start.
- control_hold_ss_i  in  1  keep SS asserted after this word; latched at start.
- control_re_i  in  1  RX read acknowledge; clears rx_valid_o and rx_ovf_o.
- mem_data_o  out  DATA_W  last received word.
- busy_o  out  1  transfer in progress.
- rx_valid_o  out  1  mem_data_o holds an unread word.
- rx_ovf_o  out  1  sticky: a word completed while rx_valid_o=1.
- SCK  out  1  SPI clock.
- SS  out  NUM_SS  active-low selects.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.

Behaviour:
- Reset (async, any state): state IDLE; SCK=0; SS all 1; MOSI=0; mem_data_o=0; busy_o, rx_valid_o, rx_ovf_o = 0; latched mode = 0.
- FSM states: IDLE, SETUP, LEAD, TRAIL, DONE. Each non-IDLE state lasts exactly one half period (div+1 clocks), counted by the sub-module tick.
- IDLE: SCK = latched CPOL. If control_we_i=1, latch all inputs. Next cycle: busy_o=1, selected SS low; any previously held SS that differs is released. Go to SETUP.
- CPHA=0: MOSI = bit DATA_W-1 in SETUP; LEAD samples MISO; TRAIL shifts out the next bit.
- CPHA=1: LEAD shifts out the next bit; TRAIL samples MISO.
- SCK = ~CPOL in LEAD and CPOL otherwise. LEAD/TRAIL alternate DATA_W times.
- After the last TRAIL:
  - hold_ss=1: go to IDLE; SS stays low.
  - hold_ss=0: go to DONE; SS rises on exit from DONE; then IDLE.
- Latency, start to busy_o falling: (2*DATA_W+2)*(div+1) clocks without hold, (2*DATA_W+1)*(div+1) with hold.
- Completion, on the cycle busy_o falls:
  - mem_data_o <= shift register; rx_valid_o <= 1.
  - If rx_valid_o was already 1 and control_re_i is not asserted in that cycle, rx_ovf_o <= 1.
  - Completion and control_re_i in the same cycle: rx_valid_o stays 1, rx_ovf_o cleared.
- control_we_i while busy_o=1: ignored, no side effect.
- control_ss_sel_i >= NUM_SS: transfer runs with no SS asserted.
- control_div_i changes mid-transfer: no effect (latched value used).

Optional Feature:
- SPI_LOOPBACK_EN defined: extra input loopback_i. When loopback_i=1 at start, the sampler uses internal MOSI instead of MISO for that transfer, and SS stays high.
- Macro undefined: port and mux absent; MISO always sampled.

Decomposition:
- Package spi_master_pkg holds:
  - mode constants SPI_MODE0..SPI_MODE3 (2'b00..2'b11);
  - FSM state encoding;
  - function ss_w(NUM_SS) returning max(1,clog2).
- Sub-module spi_sck_tick: DIV_W down-counter.
  - Reloads on start or tick.
  - Emits a one-clock tick every div+1 clocks while enabled.

Test Plan:
- DATA_W=8, mode 0, div=0, TX 0xA5, MISO drives 0x3C MSB-first on leading edges -> MOSI shows 1,0,1,0,0,1,0,1; mem_data_o=0x3C; busy_o high 18 clocks; SCK idles 0.
- Mode 3, div=3, TX 0x81, MISO 0xFF -> SCK idles 1; each SCK phase 4 clocks; mem_data_o=0xFF; busy_o high 72 clocks.
- NUM_SS=4, two words to sel=2 with hold_ss=1 then hold_ss=0 -> SS=4'b1011 continuously across both words, then 4'b1111 after DONE; a third start to sel=1 after a hold_ss=1 word -> SS[2] released, SS[1] low.
- Two back-to-back transfers with no control_re_i -> rx_ovf_o=1, mem_data_o = second word; control_re_i pulse -> rx_valid_o=0, rx_ovf_o=0.
- Assert control_rst_i=0 midway through LEAD of bit 4 -> same cycle SS all 1, busy_o=0, SCK=0; new start after release completes normally.
- control_we_i pulsed while busy with TX 0x00 -> ignored; MOSI still carries the original word, and no second transfer follows.
